// File: rtl/hazard_sequencer_pkg.sv
// Shared constants, instruction field layout and decode helpers for hazard_sequencer.
package hazard_sequencer_pkg;

    localparam int ISIZE = 16;

    localparam logic [3:0]       OP_LW     = 4'b1000;
    localparam logic [ISIZE-1:0] NOP_INSTR = 16'h7000;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BR_WAIT  = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH = 2'd2;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
    } instr_t;

    function automatic logic is_load(input logic [ISIZE-1:0] instr);
        return (instr[15:12] == OP_LW);
    endfunction

    function automatic logic is_branch(input logic [ISIZE-1:0] instr);
        return (instr[15:14] == 2'b11);
    endfunction

endpackage

// File: rtl/hazard_sequencer_dep_check.sv
// Combinational check: does the consumer instruction read the producer's destination register?
module dep_check
    import hazard_sequencer_pkg::*;
(
    input  logic [3:0]       prod_rd_i,
    input  logic [ISIZE-1:0] cons_instr_i,
    output logic             dep_o
);

    instr_t cons_s;
    logic   rs_hit_s;
    logic   rt_hit_s;
    logic   rd_hit_s;

    assign cons_s = cons_instr_i;

    // Which operand slots are actually read depends on the opcode range.
    assign rs_hit_s = (cons_s.rs == prod_rd_i) && (cons_s.op < 4'd10);
    assign rt_hit_s = (cons_s.rt == prod_rd_i) && (cons_s.op < 4'd5);
    assign rd_hit_s = (cons_s.rd == prod_rd_i) && (cons_s.op > 4'd13);

    assign dep_o = (prod_rd_i != 4'd0) && (rs_hit_s || rt_hit_s || rd_hit_s);

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use stall and branch-wait/flush controller for the IF/ID -> issue path.
// Optional macro HAZ_PERF_EN adds saturating stall performance counters.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int BR_LAT = 3
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] instr_id,
    input  logic             ext_hold,
    input  logic             br_resolve,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             bubble_sel
`ifdef HAZ_PERF_EN
    ,
    output logic [15:0]      ld_stall_cnt,
    output logic [15:0]      br_stall_cnt
`endif
);

    localparam logic [3:0] BR_LAT_M1 = 4'(BR_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ISIZE-1:0] ex_instr_q, ex_instr_d;
    logic             dep_s;
    logic             load_use_s;

    dep_check u_dep_check (
        .prod_rd_i    (ex_instr_q[11:8]),
        .cons_instr_i (instr_id),
        .dep_o        (dep_s)
    );

    assign load_use_s = is_load(ex_instr_q) && dep_s;

    // Control outputs and next-state; reset and freeze take precedence over the FSM.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        bubble_sel = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (rst) begin
            ifid_flush = 1'b1;
            bubble_sel = 1'b1;
        end else if (ext_hold) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use_s) begin
                        bubble_sel = 1'b1;
                    end else if (is_branch(instr_id)) begin
                        cnt_d   = BR_LAT_M1;
                        state_d = ST_BR_WAIT;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
                ST_BR_WAIT: begin
                    bubble_sel = 1'b1;
                    if (br_resolve || (cnt_q == 4'd0)) begin
                        state_d = ST_BR_FLUSH;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_BR_FLUSH: begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    bubble_sel = 1'b1;
                    state_d    = ST_RUN;
                end
                default: begin
                    bubble_sel = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = ST_RUN;
                end
            endcase
        end
    end

    // The instruction seen by EX next cycle is whatever the issue mux selects now.
    always_comb begin
        if (ext_hold) begin
            ex_instr_d = ex_instr_q;
        end else begin
            ex_instr_d = bubble_sel ? NOP_INSTR : instr_id;
        end
    end

    // State, branch-wait counter and last-issued instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            ex_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_instr_q <= ex_instr_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [15:0] ld_stall_cnt_q;
    logic [15:0] br_stall_cnt_q;
    logic        ld_stall_s;
    logic        br_stall_s;

    assign ld_stall_s = !ext_hold && (state_q == ST_RUN) && load_use_s;
    assign br_stall_s = !ext_hold && ((state_q == ST_BR_WAIT) || (state_q == ST_BR_FLUSH));

    // Saturating stall counters; ext_hold freezes them along with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_stall_cnt_q <= 16'd0;
            br_stall_cnt_q <= 16'd0;
        end else begin
            if (ld_stall_s && (ld_stall_cnt_q != 16'hFFFF)) begin
                ld_stall_cnt_q <= ld_stall_cnt_q + 16'd1;
            end
            if (br_stall_s && (br_stall_cnt_q != 16'hFFFF)) begin
                br_stall_cnt_q <= br_stall_cnt_q + 16'd1;
            end
        end
    end

    assign ld_stall_cnt = ld_stall_cnt_q;
    assign br_stall_cnt = br_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (default build, BR_LAT = 3).
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_id;
    logic        ext_hold;
    logic        br_resolve;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        bubble_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected control vectors: {pc_en, ifid_en, ifid_flush, bubble_sel}
    localparam logic [3:0] C_RST   = 4'b0011;
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_ISSUE = 4'b0000;
    localparam logic [3:0] C_WAIT  = 4'b0001;
    localparam logic [3:0] C_FLUSH = 4'b1011;
    localparam logic [3:0] C_HOLD  = 4'b0000;

    hazard_sequencer #(.BR_LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_id   (instr_id),
        .ext_hold   (ext_hold),
        .br_resolve (br_resolve),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .bubble_sel (bubble_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {pc_en, ifid_en, ifid_flush, bubble_sel};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("%s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check the combinational controls.
    task automatic cyc(input string tag, input logic [15:0] instr, input logic hold,
                       input logic brr, input logic [3:0] exp);
        @(negedge clk);
        instr_id   = instr;
        ext_hold   = hold;
        br_resolve = brr;
        #1;
        chk(tag, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        instr_id   = 16'h7000;
        ext_hold   = 1'b0;
        br_resolve = 1'b0;

        @(negedge clk); #1; chk("reset_0", C_RST);
        @(negedge clk); #1; chk("reset_1", C_RST);
        @(negedge clk); rst = 1'b0; #1; chk("post_reset", C_RUN);

        for (int i = 0; i < 20; i++) cyc("nop_run", 16'h7000, 1'b0, 1'b0, C_RUN);

        // Load r3, consumer via rs -> one stall cycle
        cyc("lw_issue",     16'h8312, 1'b0, 1'b0, C_RUN);
        cyc("lu_stall",     16'h0530, 1'b0, 1'b0, C_STALL);
        cyc("lu_release",   16'h0530, 1'b0, 1'b0, C_RUN);
        cyc("after_lu",     16'h7000, 1'b0, 1'b0, C_RUN);

        // Load to r0 never stalls
        cyc("lw_r0",        16'h8012, 1'b0, 1'b0, C_RUN);
        cyc("r0_consumer",  16'h0500, 1'b0, 1'b0, C_RUN);

        // rt consumer only for op < 5
        cyc("lw_r3_b",      16'h8312, 1'b0, 1'b0, C_RUN);
        cyc("rt_stall",     16'h0203, 1'b0, 1'b0, C_STALL);
        cyc("rt_release",   16'h0203, 1'b0, 1'b0, C_RUN);
        cyc("lw_r3_c",      16'h8312, 1'b0, 1'b0, C_RUN);
        cyc("rt_op5_nodep", 16'h5203, 1'b0, 1'b0, C_RUN);

        // Load-use beats branch detection, then branch resolves on first wait cycle
        cyc("lw_r3_d",      16'h8312, 1'b0, 1'b0, C_RUN);
        cyc("lu_over_br",   16'hE300, 1'b0, 1'b0, C_STALL);
        cyc("br_e_issue",   16'hE300, 1'b0, 1'b0, C_ISSUE);
        cyc("br_e_wait1",   16'hE300, 1'b0, 1'b1, C_WAIT);
        cyc("br_e_flush",   16'hE300, 1'b0, 1'b0, C_FLUSH);
        cyc("br_e_run",     16'h7000, 1'b0, 1'b0, C_RUN);

        // br_resolve in RUN is ignored
        cyc("brr_in_run",   16'h7000, 1'b0, 1'b1, C_RUN);
        cyc("brr_in_run2",  16'h7000, 1'b0, 1'b0, C_RUN);

        // Branch resolved on 2nd wait cycle
        cyc("br_a_issue",   16'hC000, 1'b0, 1'b0, C_ISSUE);
        cyc("br_a_wait1",   16'hC000, 1'b0, 1'b0, C_WAIT);
        cyc("br_a_wait2",   16'hC000, 1'b0, 1'b1, C_WAIT);
        cyc("br_a_flush",   16'hC000, 1'b0, 1'b0, C_FLUSH);
        cyc("br_a_run",     16'h7000, 1'b0, 1'b0, C_RUN);

        // Unresolved branch: exactly BR_LAT = 3 wait cycles
        cyc("br_b_issue",   16'hC000, 1'b0, 1'b0, C_ISSUE);
        cyc("br_b_wait1",   16'hC000, 1'b0, 1'b0, C_WAIT);
        cyc("br_b_wait2",   16'hC000, 1'b0, 1'b0, C_WAIT);
        cyc("br_b_wait3",   16'hC000, 1'b0, 1'b0, C_WAIT);
        cyc("br_b_flush",   16'hC000, 1'b0, 1'b0, C_FLUSH);
        cyc("br_b_run",     16'h7000, 1'b0, 1'b0, C_RUN);

        // Freeze in BR_WAIT: controls zero, br_resolve ignored, wait count preserved
        cyc("br_c_issue",   16'hC000, 1'b0, 1'b0, C_ISSUE);
        cyc("br_c_wait1",   16'hC000, 1'b0, 1'b0, C_WAIT);
        for (int i = 0; i < 4; i++) cyc("br_c_hold", 16'hC000, 1'b1, 1'b1, C_HOLD);
        cyc("br_c_wait2",   16'hC000, 1'b0, 1'b0, C_WAIT);
        cyc("br_c_wait3",   16'hC000, 1'b0, 1'b0, C_WAIT);
        cyc("br_c_flush",   16'hC000, 1'b0, 1'b0, C_FLUSH);
        cyc("br_c_run",     16'h7000, 1'b0, 1'b0, C_RUN);

        // Freeze keeps the load in EX, so the stall appears after release
        cyc("lw_hold_iss",  16'h8312, 1'b0, 1'b0, C_RUN);
        cyc("lw_hold_0",    16'h0530, 1'b1, 1'b0, C_HOLD);
        cyc("lw_hold_1",    16'h0530, 1'b1, 1'b0, C_HOLD);
        cyc("lw_hold_stall",16'h0530, 1'b0, 1'b0, C_STALL);
        cyc("lw_hold_rel",  16'h0530, 1'b0, 1'b0, C_RUN);

        // Reset mid-BR_WAIT: immediate reset controls, RUN after release, no flush
        cyc("br_d_issue",   16'hC000, 1'b0, 1'b0, C_ISSUE);
        cyc("br_d_wait1",   16'hC000, 1'b0, 1'b0, C_WAIT);
        @(negedge clk); rst = 1'b1; #1; chk("rst_mid_wait", C_RST);
        @(negedge clk); #1; chk("rst_held", C_RST);
        @(negedge clk); rst = 1'b0; instr_id = 16'h7000; #1; chk("rst_release", C_RUN);
        cyc("no_flush_after_rst", 16'h7000, 1'b0, 1'b0, C_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Sequential hazard controller between the IF/ID pipeline register and the issue mux of the 16-bit pipelined core. It tracks the instruction issued to EX in the previous cycle, stalls fetch and injects bubbles on load-use dependencies, and runs a branch-wait state machine that holds the PC until the branch resolves and then flushes the stale IF/ID entry. It drives the PC-enable, IF/ID-enable/flush and bubble-select controls of the datapath.

## Interface
- BR_LAT, 3: maximum cycles spent in BR_WAIT before forced exit; legal range 1..15.
- NOP_INSTR, 16'h7000: canonical bubble encoding; never creates or consumes a hazard.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr_id  in  `ISIZE  instruction currently held in IF/ID.
- ext_hold  in  1  global freeze (memory busy); highest priority after rst.
- br_resolve  in  1  one-cycle pulse from EX: branch/jump outcome and target are applied this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load NOP_INSTR into IF/ID this cycle (overrides ifid_en).
- bubble_sel  out  1  issue NOP_INSTR into ID/EX instead of instr_id.

## Operation
- Fields: op = [15:12], rd = [11:8], rs = [7:4], rt = [3:0]; register 0 never causes a dependency.
- Load: op == 4'b1000. Branch class: op[3:2] == 2'b11. NOP_INSTR matches neither.
- Consumer of reg r: (rs == r and op < 10) or (rt == r and op < 5) or (rd == r and op > 13), r != 0.
- ex_instr register: instruction issued last cycle; updates each non-held cycle to bubble_sel ? NOP_INSTR : instr_id.
- States: RUN, BR_WAIT, BR_FLUSH; 4-bit down-counter cnt.
- RUN, load-use (ex_instr is load, instr_id consumes ex_instr.rd): pc_en=0, ifid_en=0, bubble_sel=1, stay RUN. Takes priority over branch detection.
- RUN, instr_id branch class, no load-use: issue it (bubble_sel=0), pc_en=0, ifid_en=0; cnt <= BR_LAT-1; -> BR_WAIT.
- RUN otherwise: pc_en=1, ifid_en=1, bubble_sel=0, ifid_flush=0.
- BR_WAIT: pc_en=0, ifid_en=0, bubble_sel=1. br_resolve=1 or cnt==0 -> BR_FLUSH; else cnt <= cnt-1.
- BR_FLUSH (one cycle): pc_en=1, ifid_flush=1, bubble_sel=1 -> RUN.
- br_resolve outside BR_WAIT is ignored.
- ext_hold=1: pc_en=ifid_en=ifid_flush=bubble_sel=0; state, cnt, ex_instr (and perf counters) hold; br_resolve not sampled (EX holds its pulse while frozen).

## Timing
- Controls are combinational from state, ex_instr, instr_id, ext_hold; no input-to-state latency beyond one edge.
- Load-use stall: exactly one cycle (ex_instr becomes NOP_INSTR).
- Branch: 1 issue cycle + 1..BR_LAT BR_WAIT cycles + 1 BR_FLUSH cycle.
- While rst=1: state=RUN, cnt=0, ex_instr=NOP_INSTR; outputs pc_en=0, ifid_en=0, ifid_flush=1, bubble_sel=1. First cycle after release behaves as RUN.
- rst mid-BR_WAIT aborts immediately; no flush cycle follows.

## Configuration
- HAZ_PERF_EN defined: adds outputs ld_stall_cnt[15:0] (load-use stall cycles) and br_stall_cnt[15:0] (BR_WAIT + BR_FLUSH cycles); saturating at 16'hFFFF, cleared by rst, frozen by ext_hold.
- Undefined: ports and counters absent; control behaviour identical.

## Structure
- define.v gets ISIZE, OP_LW (4'b1000), NOP_INSTR value, state encodings (RUN=2'd0, BR_WAIT=2'd1, BR_FLUSH=2'd2).
- Sub-module dep_check: combinational; inputs producer rd and consumer instruction, output dependency flag.

## Test plan
- Reset, then 20 cycles of 16'h7000 -> pc_en=1, ifid_en=1, bubble_sel=0 every cycle; no flush.
- 16'h8312 issued then instr_id 16'h0530 -> exactly one cycle pc_en=0, bubble_sel=1; next cycle 16'h0530 issued.
- 16'h8012 then 16'h0500 (r0 consumer) -> no stall.
- 16'hC000 in RUN, br_resolve on 2nd BR_WAIT cycle -> BR_WAIT 2 cycles, BR_FLUSH 1 cycle (ifid_flush=1, pc_en=1), RUN.
- 16'hC000, no br_resolve, BR_LAT=3 -> exactly 3 BR_WAIT cycles then BR_FLUSH.
- ext_hold=1 for 4 cycles in BR_WAIT -> all controls 0, cnt unchanged; rst pulse mid-BR_WAIT -> immediate reset outputs, RUN after release, no flush cycle.
